// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared opcodes, scheduler state and command record for the mcu scheduler
// Purpose: common definitions imported by the scheduler, its arbiter and its interface users.
// Ports: none (package).
package mcu_pkg;

  // Default datapath widths; cmd_t is sized from these.
  localparam int CMD_OP_SZ  = 32;
  localparam int CMD_MEM_SZ = 10;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_READ  = 4'd7;
  localparam logic [3:0] OP_WRITE = 4'd8;
  localparam logic [3:0] OP_MAX   = 4'd8;
  // A read of address 0 never mutates memory, so it doubles as the idle command.
  localparam logic [3:0] OP_NOP   = OP_READ;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  typedef struct packed {
    logic [3:0]            op;
    logic [CMD_MEM_SZ-1:0] op0;
    logic [CMD_OP_SZ-1:0]  op1;
    logic [CMD_MEM_SZ-1:0] op2;
  } cmd_t;

endpackage

// File: rtl/mcu_req_sched_if.sv
// rtl/mcu_req_sched_if.sv - bundle of requester, response and mcu signals for the scheduler
// Purpose: groups the two command sources, the response channel and the mcu command port.
// Ports: r0_*/r1_* command handshakes, rsp_* response handshake, mcu_* datapath command/result.
//   modport slave  : the scheduler side
//   modport master : the requesters, response consumer and mcu side
interface mcu_req_sched_if #(
  parameter int OP_SZ  = 32,
  parameter int MEM_SZ = 10
);
  logic              r0_valid;
  logic              r0_ready;
  logic [3:0]        r0_op;
  logic [MEM_SZ-1:0] r0_op0;
  logic [OP_SZ-1:0]  r0_op1;
  logic [MEM_SZ-1:0] r0_op2;

  logic              r1_valid;
  logic              r1_ready;
  logic [3:0]        r1_op;
  logic [MEM_SZ-1:0] r1_op0;
  logic [OP_SZ-1:0]  r1_op1;
  logic [MEM_SZ-1:0] r1_op2;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [OP_SZ-1:0]  rsp_data;
  logic              rsp_err;

  logic [3:0]        mcu_op;
  logic [MEM_SZ-1:0] mcu_op0;
  logic [OP_SZ-1:0]  mcu_op1;
  logic [MEM_SZ-1:0] mcu_op2;
  logic [OP_SZ-1:0]  mcu_out;
  logic              mcu_op_err;

  modport slave (
    input  r0_valid, r0_op, r0_op0, r0_op1, r0_op2,
    output r0_ready,
    input  r1_valid, r1_op, r1_op0, r1_op1, r1_op2,
    output r1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready,
    output mcu_op, mcu_op0, mcu_op1, mcu_op2,
    input  mcu_out, mcu_op_err
  );

  modport master (
    output r0_valid, r0_op, r0_op0, r0_op1, r0_op2,
    input  r0_ready,
    output r1_valid, r1_op, r1_op0, r1_op1, r1_op2,
    input  r1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready,
    input  mcu_op, mcu_op0, mcu_op1, mcu_op2,
    output mcu_out, mcu_op_err
  );
endinterface

// File: rtl/mcu_rr_arb2.sv
// rtl/mcu_rr_arb2.sv - two-way round-robin grant with last-grant pointer
// Purpose: picks one of two requesters; on a tie the one not granted last time wins.
// Ports: clk, reset (async active-low), req[1:0] requests, adv (commit grant when set),
//        gnt[1:0] one-hot grant (combinational).
module mcu_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);
  // Reset value 1 lets requester 0 win the first tie.
  logic last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (adv && (|req)) begin
      last_q <= gnt[1];
    end
  end
endmodule

// File: rtl/mcu_req_sched.sv
// rtl/mcu_req_sched.sv - two-requester round-robin command scheduler in front of the mcu
// Purpose: accepts one command at a time from r0/r1, issues it to the mcu for one cycle,
//   waits LAT cycles, then returns the captured mcu result to the winner. Between commands
//   the mcu sees a NOP (read of address 0).
// Ports: clk, reset (async active-low), bus (mcu_req_sched_if.slave: r0_*/r1_* commands,
//   rsp_* response, mcu_* datapath port).
// Parameters: OP_SZ/MEM_SZ must equal the mcu_pkg cmd_t widths; LAT >= 1.
// Option: MCU_SCHED_OPCHK_EN - opcodes above OP_MAX are answered locally with rsp_err=1,
//   rsp_data=0 and never reach the mcu.
module mcu_req_sched
  import mcu_pkg::*;
#(
  parameter int OP_SZ  = CMD_OP_SZ,
  parameter int MEM_SZ = CMD_MEM_SZ,
  parameter int LAT    = 1
) (
  input logic            clk,
  input logic            reset,
  mcu_req_sched_if.slave bus
);
  localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

  sched_state_t     state_q, state_d;
  cmd_t             cmd_q, cmd_d, sel_cmd;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_q, id_d;
  logic [OP_SZ-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [1:0]       gnt;

  mcu_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.r1_valid, bus.r0_valid}),
    .adv   (state_q == IDLE),
    .gnt   (gnt)
  );

  always_comb begin
    if (gnt[1]) begin
      sel_cmd = '{op: bus.r1_op, op0: bus.r1_op0, op1: bus.r1_op1, op2: bus.r1_op2};
    end else begin
      sel_cmd = '{op: bus.r0_op, op0: bus.r0_op0, op1: bus.r0_op1, op2: bus.r0_op2};
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    data_d       = data_q;
    err_d        = err_q;
    bus.r0_ready = 1'b0;
    bus.r1_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mcu_op   = OP_NOP;
    bus.mcu_op0  = MEM_SZ'(0);
    bus.mcu_op1  = OP_SZ'(0);
    bus.mcu_op2  = MEM_SZ'(0);

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          bus.r0_ready = gnt[0];
          bus.r1_ready = gnt[1];
          cmd_d        = sel_cmd;
          id_d         = gnt[1];
`ifdef MCU_SCHED_OPCHK_EN
          if (sel_cmd.op > OP_MAX) begin
            state_d = RESP;
            data_d  = '0;
            err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        bus.mcu_op  = cmd_q.op;
        bus.mcu_op0 = cmd_q.op0;
        bus.mcu_op1 = cmd_q.op1;
        bus.mcu_op2 = cmd_q.op2;
        cnt_d       = CNT_W'(LAT);
        state_d     = WAIT;
      end
      WAIT: begin
        // The count reaches 1 on the cycle in which mcu_out holds this command's result.
        if (cnt_q == CNT_W'(1)) begin
          data_d  = bus.mcu_out;
          err_d   = bus.mcu_op_err;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.rsp_id   = id_q;
  assign bus.rsp_data = data_q;
  assign bus.rsp_err  = err_q;
endmodule

// File: tb/tb_mcu_req_sched.sv
// tb/tb_mcu_req_sched.sv - self-checking bench for mcu_req_sched
`timescale 1ns/1ps
module tb_mcu_req_sched;
  import mcu_pkg::*;

  localparam int OP_SZ  = 32;
  localparam int MEM_SZ = 10;
  localparam int LAT    = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mcu_req_sched_if #(.OP_SZ(OP_SZ), .MEM_SZ(MEM_SZ)) bus ();

  mcu_req_sched #(.OP_SZ(OP_SZ), .MEM_SZ(MEM_SZ), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OP_SZ-1:0] alu(input logic [3:0] op, input logic [OP_SZ-1:0] a,
                                           input logic [OP_SZ-1:0] b);
    case (op)
      4'd0: alu = a + b;
      4'd1: alu = a - b;
      4'd2: alu = a * b;
      4'd3: alu = (b == 0) ? '0 : a / b;
      4'd4: alu = a & b;
      4'd5: alu = a | b;
      4'd6: alu = a ^ b;
      default: alu = '0;
    endcase
  endfunction

  // ---------------- mcu behavioural model (LAT = 1) ----------------
  logic [OP_SZ-1:0]  mcu_mem [1 << MEM_SZ];
  logic [3:0]        m_op;
  logic [MEM_SZ-1:0] m_a0, m_a2;
  logic [OP_SZ-1:0]  m_a1, m_r;

  always @(negedge clk) begin
    m_op = bus.mcu_op; m_a0 = bus.mcu_op0; m_a1 = bus.mcu_op1; m_a2 = bus.mcu_op2;
  end

  always @(posedge clk) begin
    m_r = '0;
    if (m_op <= 4'd6) begin
      m_r = alu(m_op, mcu_mem[m_a0], mcu_mem[m_a1[MEM_SZ-1:0]]);
      mcu_mem[m_a2] <= m_r;
    end else if (m_op == 4'd7) begin
      m_r = mcu_mem[m_a0];
    end else if (m_op == 4'd8) begin
      m_r = m_a1;
      mcu_mem[m_a0] <= m_a1;
    end
    bus.mcu_out    <= m_r;
    bus.mcu_op_err <= (m_op > 4'd8);
  end

  // ---------------- transaction-level reference model ----------------
  logic [OP_SZ-1:0] sb_mem [1 << MEM_SZ];

  task automatic sb_exec(input logic [3:0] op, input logic [MEM_SZ-1:0] a0,
                         input logic [OP_SZ-1:0] a1, input logic [MEM_SZ-1:0] a2,
                         output logic [OP_SZ-1:0] d, output logic e);
    e = (op > 4'd8);
    d = '0;
    if (op <= 4'd6) begin
      d = alu(op, sb_mem[a0], sb_mem[a1[MEM_SZ-1:0]]);
      sb_mem[a2] = d;
    end else if (op == 4'd7) begin
      d = sb_mem[a0];
    end else if (op == 4'd8) begin
      sb_mem[a0] = a1;
      d = a1;
    end
  endtask

  // Timeline of one command, counted in cycles since its grant:
  // 0 grant (NOP), 1 issued on mcu, 2..LAT+1 NOP, LAT+2.. response held until taken.
  bit               chk_en = 1'b0;
  bit               busy = 1'b0;
  int               age = 0;
  int               cg;
  logic             last_g = 1'b1;
  logic             acc0 = 1'b0, acc1 = 1'b0;
  logic             e_id, e_err;
  logic [3:0]       e_op;
  logic [MEM_SZ-1:0] e_a0, e_a2;
  logic [OP_SZ-1:0] e_a1, e_data;
  int               op12_cnt = 0;

  always @(negedge clk) begin
    if (bus.mcu_op == 4'd12) op12_cnt++;
    if (!reset) begin
      busy = 1'b0; last_g = 1'b1; acc0 = 1'b0; acc1 = 1'b0;
    end else if (chk_en) begin
      acc0 = bus.r0_valid & bus.r0_ready;
      acc1 = bus.r1_valid & bus.r1_ready;
      if (!busy) begin
        cg = -1;
        if (bus.r0_valid && bus.r1_valid) cg = last_g ? 0 : 1;
        else if (bus.r0_valid) cg = 0;
        else if (bus.r1_valid) cg = 1;
        chk("idle_r0_ready", bus.r0_ready, cg == 0);
        chk("idle_r1_ready", bus.r1_ready, cg == 1);
        chk("idle_mcu_op", bus.mcu_op, OP_NOP);
        chk("idle_mcu_op0", bus.mcu_op0, 0);
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        if (cg >= 0) begin
          last_g = cg[0];
          e_id = cg[0];
          if (cg == 0) begin
            e_op = bus.r0_op; e_a0 = bus.r0_op0; e_a1 = bus.r0_op1; e_a2 = bus.r0_op2;
          end else begin
            e_op = bus.r1_op; e_a0 = bus.r1_op0; e_a1 = bus.r1_op1; e_a2 = bus.r1_op2;
          end
          sb_exec(e_op, e_a0, e_a1, e_a2, e_data, e_err);
          busy = 1'b1;
          age = 0;
`ifdef MCU_SCHED_OPCHK_EN
          if (e_op > OP_MAX) age = LAT + 1;
`endif
        end
      end else begin
        age++;
        chk("busy_r0_ready", bus.r0_ready, 0);
        chk("busy_r1_ready", bus.r1_ready, 0);
        if (age == 1) begin
          chk("issue_mcu_op", bus.mcu_op, e_op);
          chk("issue_mcu_op0", bus.mcu_op0, e_a0);
          chk("issue_mcu_op1", bus.mcu_op1, e_a1);
          chk("issue_mcu_op2", bus.mcu_op2, e_a2);
          chk("issue_rsp_valid", bus.rsp_valid, 0);
        end else if (age <= LAT + 1) begin
          chk("wait_mcu_op", bus.mcu_op, OP_NOP);
          chk("wait_mcu_op0", bus.mcu_op0, 0);
          chk("wait_rsp_valid", bus.rsp_valid, 0);
        end else begin
          chk("resp_valid", bus.rsp_valid, 1);
          chk("resp_id", bus.rsp_id, e_id);
          chk("resp_data", bus.rsp_data, e_data);
          chk("resp_err", bus.rsp_err, e_err);
          chk("resp_mcu_op", bus.mcu_op, OP_NOP);
          if (bus.rsp_ready) busy = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int id, input logic v, input logic [3:0] op, input logic [MEM_SZ-1:0] a0,
                       input logic [OP_SZ-1:0] a1, input logic [MEM_SZ-1:0] a2);
    if (id == 0) begin
      bus.r0_valid = v; bus.r0_op = op; bus.r0_op0 = a0; bus.r0_op1 = a1; bus.r0_op2 = a2;
    end else begin
      bus.r1_valid = v; bus.r1_op = op; bus.r1_op0 = a0; bus.r1_op1 = a1; bus.r1_op2 = a2;
    end
  endtask

  task automatic send(input int id, input logic [3:0] op, input logic [MEM_SZ-1:0] a0,
                      input logic [OP_SZ-1:0] a1, input logic [MEM_SZ-1:0] a2,
                      output logic [OP_SZ-1:0] d, output logic e, output logic rid);
    bit ok;
    d = '0; e = 1'b0; rid = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    drive(id, 1'b1, op, a0, a1, a2);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = (id == 0) ? bus.r0_ready : bus.r1_ready;
    end
    if (!ok) chk("send_accept_timeout", 0, 1);
    @(posedge clk); #1;
    drive(id, 1'b0, op, a0, a1, a2);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = bus.rsp_valid;
    end
    if (!ok) chk("send_rsp_timeout", 0, 1);
    d = bus.rsp_data; e = bus.rsp_err; rid = bus.rsp_id;
  endtask

  typedef struct {
    logic [3:0]        op;
    logic [MEM_SZ-1:0] a0;
    logic [OP_SZ-1:0]  a1;
    logic [MEM_SZ-1:0] a2;
    logic [OP_SZ-1:0]  d;
    logic              e;
  } vec_t;

  initial begin
    vec_t vt[15];
    logic [OP_SZ-1:0] d;
    logic e, rid;
    int gid[$];
    int gcyc[$];
    logic rids[$];
    logic [OP_SZ-1:0] rdat[$];
    bit ok;

    vt[0]  = '{OP_ADD,   10'd4,    32'd3,          10'd6,  32'd44,         1'b0};
    vt[1]  = '{OP_READ,  10'd6,    32'd0,          10'd0,  32'd44,         1'b0};
    vt[2]  = '{OP_SUB,   10'd4,    32'd3,          10'd7,  32'd6,          1'b0};
    vt[3]  = '{OP_READ,  10'd7,    32'd0,          10'd0,  32'd6,          1'b0};
    vt[4]  = '{OP_MUL,   10'd3,    32'd4,          10'd8,  32'd475,        1'b0};
    vt[5]  = '{OP_DIV,   10'd4,    32'd3,          10'd9,  32'd1,          1'b0};
    vt[6]  = '{OP_DIV,   10'd4,    32'd0,          10'd10, 32'd0,          1'b0};
    vt[7]  = '{OP_AND,   10'd3,    32'd4,          10'd11, 32'd17,         1'b0};
    vt[8]  = '{OP_OR,    10'd3,    32'd4,          10'd12, 32'd27,         1'b0};
    vt[9]  = '{OP_XOR,   10'd3,    32'd4,          10'd13, 32'd10,         1'b0};
    vt[10] = '{OP_SUB,   10'd3,    32'd4,          10'd14, 32'hFFFF_FFFA,  1'b0};
    vt[11] = '{OP_WRITE, 10'd1023, 32'hDEAD_BEEF,  10'd0,  32'hDEAD_BEEF,  1'b0};
    vt[12] = '{OP_READ,  10'd1023, 32'd0,          10'd0,  32'hDEAD_BEEF,  1'b0};
    vt[13] = '{OP_READ,  10'd0,    32'd0,          10'd0,  32'd0,          1'b0};
    vt[14] = '{4'd15,    10'd5,    32'd5,          10'd5,  32'd0,          1'b1};

    for (int i = 0; i < (1 << MEM_SZ); i++) begin
      mcu_mem[i] = '0; sb_mem[i] = '0;
    end
    bus.mcu_out = '0; bus.mcu_op_err = 1'b0; bus.rsp_ready = 1'b0;
    drive(0, 1'b0, 4'd0, '0, '0, '0);
    drive(1, 1'b0, 4'd0, '0, '0, '0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_mcu_op", bus.mcu_op, OP_NOP);
    chk("rst_mcu_ops", {bus.mcu_op0, bus.mcu_op1, bus.mcu_op2}, 0);
    chk("rst_ready", {bus.r0_ready, bus.r1_ready}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk_en = 1'b1;

    // 1: simultaneous writes, r0 first
    bus.rsp_ready = 1'b1;
    drive(0, 1'b1, OP_WRITE, 10'd3, 32'd19, 10'd0);
    drive(1, 1'b1, OP_WRITE, 10'd4, 32'd25, 10'd0);
    @(negedge clk);
    chk("t1_first_r0_ready", bus.r0_ready, 1);
    chk("t1_first_r1_ready", bus.r1_ready, 0);
    for (int c = 0; c < 30 && rids.size() < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.rsp_valid) begin rids.push_back(bus.rsp_id); rdat.push_back(bus.rsp_data);
        chk("t1_err", bus.rsp_err, 0); end
      @(posedge clk); #1;
      if (acc0) bus.r0_valid = 1'b0;
      if (acc1) bus.r1_valid = 1'b0;
    end
    chk("t1_rsp_count", rids.size(), 2);
    if (rids.size() == 2) begin
      chk("t1_id0", rids[0], 0); chk("t1_id1", rids[1], 1);
      chk("t1_data0", rdat[0], 19); chk("t1_data1", rdat[1], 25);
    end

    // 3: both requesters continuously valid -> alternating grants, LAT+3 apart
    repeat (3) @(posedge clk); #1;
    drive(0, 1'b1, OP_READ, 10'd3, 32'd0, 10'd0);
    drive(1, 1'b1, OP_READ, 10'd4, 32'd0, 10'd0);
    for (int c = 0; c < 60 && gid.size() < 4; c++) begin
      @(negedge clk);
      if (bus.r0_ready) begin gid.push_back(0); gcyc.push_back(c); end
      if (bus.r1_ready) begin gid.push_back(1); gcyc.push_back(c); end
    end
    @(posedge clk); #1;
    drive(0, 1'b0, OP_READ, 10'd3, 32'd0, 10'd0);
    drive(1, 1'b0, OP_READ, 10'd4, 32'd0, 10'd0);
    chk("t3_grant_count", gid.size(), 4);
    if (gid.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t3_grant_order", gid[i], i % 2);
      for (int i = 1; i < 4; i++) chk("t3_spacing", gcyc[i] - gcyc[i-1], LAT + 3);
    end
    repeat (8) @(posedge clk);

    // 2: table of single-requester commands
    for (int i = 0; i < 15; i++) begin
      send(0, vt[i].op, vt[i].a0, vt[i].a1, vt[i].a2, d, e, rid);
      chk($sformatf("tbl%0d_data", i), d, vt[i].d);
      chk($sformatf("tbl%0d_err", i), e, vt[i].e);
      chk($sformatf("tbl%0d_id", i), rid, 0);
    end

    // 4: response back-pressure with a competing request pending
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    drive(1, 1'b1, OP_READ, 10'd6, 32'd0, 10'd0);
    @(negedge clk);
    chk("t4_r1_ready", bus.r1_ready, 1);
    @(posedge clk); #1;
    drive(1, 1'b0, OP_READ, 10'd6, 32'd0, 10'd0);
    drive(0, 1'b1, OP_READ, 10'd7, 32'd0, 10'd0);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = bus.rsp_valid; end
    chk("t4_rsp_seen", ok, 1);
    for (int n = 0; n < 5; n++) begin
      if (n > 0) @(negedge clk);
      chk("t4_hold_valid", bus.rsp_valid, 1);
      chk("t4_hold_data", bus.rsp_data, 44);
      chk("t4_hold_id", bus.rsp_id, 1);
      chk("t4_hold_r0_ready", bus.r0_ready, 0);
      chk("t4_hold_mcu_op", bus.mcu_op, OP_NOP);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = bus.r0_ready; end
    chk("t4_r0_after", ok, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, OP_READ, 10'd7, 32'd0, 10'd0);
    repeat (6) @(posedge clk);

    // 5: out-of-range opcode from r1
    op12_cnt = 0;
    send(1, 4'd12, 10'd2, 32'd2, 10'd2, d, e, rid);
    chk("t5_err", e, 1);
    chk("t5_data", d, 0);
    chk("t5_id", rid, 1);
`ifdef MCU_SCHED_OPCHK_EN
    chk("t5_mcu_saw_12", op12_cnt, 0);
`else
    chk("t5_mcu_saw_12", op12_cnt, 1);
`endif
    repeat (3) @(posedge clk);

    // 6: reset during WAIT
    @(posedge clk); #1;
    drive(0, 1'b1, OP_READ, 10'd6, 32'd0, 10'd0);
    @(negedge clk);
    chk("t6_accept", bus.r0_ready, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, OP_READ, 10'd6, 32'd0, 10'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("t6_rsp_valid", bus.rsp_valid, 0);
    chk("t6_mcu_op", bus.mcu_op, OP_NOP);
    chk("t6_mcu_op0", bus.mcu_op0, 0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 1'b1, OP_READ, 10'd3, 32'd0, 10'd0);
    drive(1, 1'b1, OP_READ, 10'd4, 32'd0, 10'd0);
    @(negedge clk);
    chk("t6_tie_r0", bus.r0_ready, 1);
    chk("t6_tie_r1", bus.r1_ready, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, OP_READ, 10'd3, 32'd0, 10'd0);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = bus.r1_ready; end
    chk("t6_r1_next", ok, 1);
    @(posedge clk); #1;
    drive(1, 1'b0, OP_READ, 10'd4, 32'd0, 10'd0);
    repeat (6) @(posedge clk);

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        logic v, a;
        logic [3:0] op;
        v = (r == 0) ? bus.r0_valid : bus.r1_valid;
        a = (r == 0) ? acc0 : acc1;
        if (!v || a) begin
          op = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
          drive(r, ($urandom_range(0, 2) != 0), op, MEM_SZ'($urandom_range(0, 15)),
                (op == OP_WRITE) ? OP_SZ'($urandom) : OP_SZ'($urandom_range(0, 15)),
                MEM_SZ'($urandom_range(0, 15)));
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("end_idle", bus.rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
